// File: rtl/ca_scroll_renderer.sv
// Scrolling 1-D elementary cellular automaton renderer: every cell row on screen
// is the next generation of the row above, and each frame starts one generation later.
`timescale 1ns/1ps
module ca_scroll_renderer #(
  parameter int         GRID_W    = 100,
  parameter int         LOG_CELL  = 2,
  parameter int         H_RES     = 640,
  parameter int         V_RES     = 480,
  parameter int         WRAP      = 1,
  parameter logic [7:0] RULE_INIT = 8'd30,
  parameter logic [5:0] ON_COLOR  = 6'b101100,
  parameter logic [5:0] OFF_COLOR = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_active,
  input  logic [7:0]  rule_in,
  input  logic        pause,
  input  logic        reseed,
  output logic [5:0]  rgb,
  output logic        cell_on,
  output logic        busy,
  output logic [15:0] gen_count
);

  localparam int CELL     = 1 << LOG_CELL;
  localparam int GRID_PIX = GRID_W * CELL;
  localparam int PAD      = (H_RES - GRID_PIX) / 2;
  localparam int CW       = $clog2(GRID_W);

  localparam logic [GRID_W-1:0] SEED     = {{(GRID_W-1){1'b0}}, 1'b1} << (GRID_W / 2);
  localparam logic [9:0]        ROW_MASK = 10'(CELL - 1);
  localparam logic [9:0]        LAST_Y   = 10'(V_RES - 1);
  localparam logic [CW-1:0]     LAST_K   = CW'(GRID_W - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_SWAP    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     k_q, k_d;
  logic [GRID_W-1:0] nxt_q, nxt_d;
  logic [GRID_W-1:0] row_q, row_d;
  logic [GRID_W-1:0] top_q, top_d;
  logic [15:0]       gen_q, gen_d;
  logic [7:0]        rule_q, rule_d;
  logic              first_q, first_d;
  logic              pend_q, pend_d;
  logic              va_q, va_d;
  logic              busy_q, busy_d;
  logic              cell_on_q, cell_on_d;
  logic [5:0]        rgb_q, rgb_d;

  logic [11:0]       dx_s;
  logic [CW-1:0]     cell_s;
  logic              in_grid_s;
  logic              line_end_s;
  logic              frame_end_s;
  logic              row_end_s;
  logic              l_s, c_s, r_s;

  // Left of the grid dx wraps to a value far above GRID_PIX, so one compare bounds both sides.
  always_comb begin
    dx_s      = {2'b00, pix_x} - 12'(PAD);
    in_grid_s = video_active && (dx_s < 12'(GRID_PIX));
    cell_s    = CW'(dx_s >> LOG_CELL);
    cell_on_d = in_grid_s && row_q[cell_s];
    if (cell_on_d) begin
      rgb_d = ON_COLOR;
    end else if (in_grid_s) begin
      rgb_d = OFF_COLOR;
    end else begin
      rgb_d = 6'd0;
    end
  end

  always_comb begin
    va_d        = video_active;
    line_end_s  = va_q && !video_active;
    frame_end_s = line_end_s && (pix_y == LAST_Y);
    row_end_s   = ((pix_y & ROW_MASK) == ROW_MASK) && (pix_y != LAST_Y);

    c_s = row_q[k_q];
    if (k_q == {CW{1'b0}}) begin
      l_s = (WRAP != 0) ? row_q[GRID_W-1] : 1'b0;
    end else begin
      l_s = row_q[k_q - CW'(1)];
    end
    if (k_q == LAST_K) begin
      r_s = (WRAP != 0) ? row_q[0] : 1'b0;
    end else begin
      r_s = row_q[k_q + CW'(1)];
    end

    state_d = state_q;
    k_d     = k_q;
    nxt_d   = nxt_q;
    row_d   = row_q;
    top_d   = top_q;
    gen_d   = gen_q;
    rule_d  = rule_q;
    first_d = first_q;
    pend_d  = pend_q | reseed;

    case (state_q)
      S_IDLE: begin
        if (line_end_s && row_end_s) begin
          state_d = S_COMPUTE;
          k_d     = {CW{1'b0}};
          first_d = (pix_y == ROW_MASK);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        nxt_d[k_q] = rule_q[{l_s, c_s, r_s}];
        if (k_q == LAST_K) begin
          state_d = S_SWAP;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      S_SWAP: begin
        row_d   = nxt_q;
        state_d = S_IDLE;
        // Only the first row of a frame seeds the next frame, and only when not paused.
        if (first_q && !pause) begin
          top_d = nxt_q;
          gen_d = gen_q + 16'd1;
        end else begin
          top_d = top_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (frame_end_s) begin
      rule_d = rule_in;
      pend_d = reseed;
      if (pend_q) begin
        top_d = SEED;
        row_d = SEED;
        gen_d = 16'd0;
      end else begin
        row_d = top_q;
      end
    end else begin
      rule_d = rule_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= {CW{1'b0}};
      nxt_q     <= {GRID_W{1'b0}};
      row_q     <= SEED;
      top_q     <= SEED;
      gen_q     <= 16'd0;
      rule_q    <= RULE_INIT;
      first_q   <= 1'b0;
      pend_q    <= 1'b0;
      va_q      <= 1'b0;
      busy_q    <= 1'b0;
      cell_on_q <= 1'b0;
      rgb_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      nxt_q     <= nxt_d;
      row_q     <= row_d;
      top_q     <= top_d;
      gen_q     <= gen_d;
      rule_q    <= rule_d;
      first_q   <= first_d;
      pend_q    <= pend_d;
      va_q      <= va_d;
      busy_q    <= busy_d;
      cell_on_q <= cell_on_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign cell_on   = cell_on_q;
  assign busy      = busy_q;
  assign gen_count = gen_q;

endmodule
